fluxo_dados_jogo: RTL

FLUXO_DADOS_JOGO -- requirements
Module: fluxo_dados_jogo

---
 rtl/fluxo_dados_jogo_if.sv | 60 ++++++
 rtl/fluxo_dados_jogo.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fluxo_dados_jogo_if.sv
// fluxo_dados_jogo_if -- control/status bundle between the game controller and
// the game datapath (fluxo_dados_jogo).
//   master : controller side, drives the control strobes, mode request and
//            player switches, and observes status/debug outputs.
//   slave  : datapath side (fluxo_dados_jogo).
// Parameters W and DEPTH must match the datapath instance; AW = clog2(DEPTH).
interface fluxo_dados_jogo_if #(
  parameter int W     = 4,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  // Control strobes
  logic          zera_endereco;
  logic          conta_endereco;
  logic          zera_limite;
  logic          conta_limite;
  logic          zera_jogada;
  logic          registra_jogada;
  logic          escreve_mem;
  logic          zera_timeout;
  logic          registra_modo;
  logic          modo;
  logic [W-1:0]  chaves;

  // Status
  logic          igual;
  logic          endereco_igual_limite;
  logic          fim_endereco;
  logic          fim_limite;
  logic          jogada_feita;
  logic          tem_jogada;
  logic          timeout;
  logic          modo_travado;

  // Debug
  logic [AW-1:0] db_endereco;
  logic [AW-1:0] db_limite;
  logic [W-1:0]  db_memoria;
  logic [W-1:0]  db_jogada;
  logic          db_modo;

  modport master (
    output zera_endereco, conta_endereco, zera_limite, conta_limite,
           zera_jogada, registra_jogada, escreve_mem, zera_timeout,
           registra_modo, modo, chaves,
    input  igual, endereco_igual_limite, fim_endereco, fim_limite,
           jogada_feita, tem_jogada, timeout, modo_travado,
           db_endereco, db_limite, db_memoria, db_jogada, db_modo
  );

  modport slave (
    input  zera_endereco, conta_endereco, zera_limite, conta_limite,
           zera_jogada, registra_jogada, escreve_mem, zera_timeout,
           registra_modo, modo, chaves,
    output igual, endereco_igual_limite, fim_endereco, fim_limite,
           jogada_feita, tem_jogada, timeout, modo_travado,
           db_endereco, db_limite, db_memoria, db_jogada, db_modo
  );
endinterface

// File: rtl/fluxo_dados_jogo.sv
// fluxo_dados_jogo -- datapath of the memory game.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears all state except memory contents
//   bus   : fluxo_dados_jogo_if.slave
//           inputs  : counter/register/memory/timeout/mode control strobes, chaves
//           outputs : igual, endereco_igual_limite, fim_endereco, fim_limite,
//                     jogada_feita, tem_jogada, timeout, modo_travado, db_*
// Contents: address and round-limit counters, DEPTH x W synchronous RAM
// (read-old-data on collision), jogada register, press edge detector,
// idle timeout counter (normal / fast mode) and one-shot mode lock.
// Optional feature: define FLUXO_TIMEOUT_EN to build the idle timeout counter;
// without it, timeout is tied to 0.
module fluxo_dados_jogo #(
  parameter int W              = 4,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic               clock,
  input  logic               reset,
  fluxo_dados_jogo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  if (W < 1 || W > 16 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 4 || (TIMEOUT_CYCLES % 2) != 0) begin : g_param_check
    $error("fluxo_dados_jogo: illegal parameter combination");
  end

  logic [AW-1:0] endereco;
  logic [AW-1:0] limite;
  logic [W-1:0]  jogada;
  logic [W-1:0]  memoria;
  logic [W-1:0]  mem [DEPTH];
  logic          tem_jogada;
  logic          tem_jogada_p1;
  logic          db_modo;
  logic          modo_travado;

  assign tem_jogada = |bus.chaves;

  // Address and round-limit counters (clear wins over increment, natural wrap)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco <= '0;
      limite   <= '0;
    end else begin
      if (bus.zera_endereco)
        endereco <= '0;
      else if (bus.conta_endereco)
        endereco <= endereco + 1'b1;

      if (bus.zera_limite)
        limite <= '0;
      else if (bus.conta_limite)
        limite <= limite + 1'b1;
    end
  end

  // Jogada register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      jogada <= '0;
    else if (bus.zera_jogada)
      jogada <= '0;
    else if (bus.registra_jogada)
      jogada <= bus.chaves;
  end

  // Memory: the write sits in the reset branch's else so an asserted reset
  // blocks it; the array itself is never cleared. The read uses the
  // pre-write contents, so a same-address write shows up one clock later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memoria <= '0;
    end else begin
      memoria <= mem[endereco];
      if (bus.escreve_mem)
        mem[endereco] <= jogada;
    end
  end

  // Press edge detector history
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      tem_jogada_p1 <= 1'b0;
    else
      tem_jogada_p1 <= tem_jogada;
  end

  // Mode capture: first registra_modo wins, later ones are ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_modo      <= 1'b0;
      modo_travado <= 1'b0;
    end else if (bus.registra_modo && !modo_travado) begin
      db_modo      <= bus.modo;
      modo_travado <= 1'b1;
    end
  end

`ifdef FLUXO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] conta_timeout;
  logic [TW-1:0] limite_timeout_m1;
  logic          muda_modo;
  logic          contagem_obsoleta;

  assign limite_timeout_m1 = db_modo ? TW'(TIMEOUT_CYCLES / 2 - 1)
                                     : TW'(TIMEOUT_CYCLES - 1);
  assign muda_modo = bus.registra_modo && !modo_travado && (bus.modo != db_modo);

  // contagem_obsoleta marks a count value that was reached by a limit change
  // rather than by counting; it masks timeout until the counter next moves,
  // and the >= compare makes such an overshoot wrap straight to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conta_timeout     <= '0;
      contagem_obsoleta <= 1'b0;
    end else if (bus.zera_timeout) begin
      conta_timeout     <= '0;
      contagem_obsoleta <= muda_modo;
    end else if (!tem_jogada) begin
      conta_timeout     <= (conta_timeout >= limite_timeout_m1) ? '0
                                                               : conta_timeout + 1'b1;
      contagem_obsoleta <= muda_modo;
    end else if (muda_modo) begin
      contagem_obsoleta <= 1'b1;
    end
  end

  assign bus.timeout = (conta_timeout == limite_timeout_m1) && !contagem_obsoleta;
`else
  logic unused_zera_timeout;
  assign unused_zera_timeout = bus.zera_timeout;
  assign bus.timeout = 1'b0;
`endif

  assign bus.igual                 = (memoria == jogada);
  assign bus.endereco_igual_limite = (endereco == limite);
  assign bus.fim_endereco          = (endereco == AW'(DEPTH - 1));
  assign bus.fim_limite            = (limite == AW'(DEPTH - 1));
  assign bus.jogada_feita          = tem_jogada && !tem_jogada_p1;
  assign bus.tem_jogada            = tem_jogada;
  assign bus.modo_travado          = modo_travado;
  assign bus.db_endereco           = endereco;
  assign bus.db_limite             = limite;
  assign bus.db_memoria            = memoria;
  assign bus.db_jogada             = jogada;
  assign bus.db_modo               = db_modo;

endmodule
